// File: rtl/perceptron_pkg.sv
// Shared fixed-point widths, trainer FSM encoding and clamping helpers.
// The helpers are used when PERCEPTRON_TRAINER_SATURATE_EN is defined.
package perceptron_pkg;

    localparam int FP_INT_W   = 4;
    localparam int FP_FRACT_W = 12;
    localparam int FP_W       = FP_INT_W + FP_FRACT_W;

    localparam logic [FP_W-1:0] FP_MAX = {1'b0, {(FP_W-1){1'b1}}};
    localparam logic [FP_W-1:0] FP_MIN = {1'b1, {(FP_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        CHECK = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5
    } state_t;

    // Clamp a shifted double-width product into the fixed-point range.
    function automatic logic [FP_W-1:0] sat_trunc(input logic signed [2*FP_W-1:0] v);
        logic signed [2*FP_W-1:0] hi;
        logic signed [2*FP_W-1:0] lo;
        hi = $signed({{FP_W{1'b0}}, FP_MAX});
        lo = $signed({{FP_W{1'b1}}, FP_MIN});
        if (v > hi) begin
            return FP_MAX;
        end else if (v < lo) begin
            return FP_MIN;
        end else begin
            return v[FP_W-1:0];
        end
    endfunction

    // Clamp a one-bit-wider sum into the fixed-point range.
    function automatic logic [FP_W-1:0] sat_add(input logic signed [FP_W:0] v);
        if (v[FP_W] != v[FP_W-1]) begin
            return v[FP_W] ? FP_MIN : FP_MAX;
        end else begin
            return v[FP_W-1:0];
        end
    endfunction

endpackage

// File: rtl/perceptron_weight_update.sv
// One weight of the learning rule: w_new = w + err * ((x * lr) >>> frac).
// PERCEPTRON_TRAINER_SATURATE_EN selects clamping instead of two's-complement wrap.
module perceptron_weight_update
    import perceptron_pkg::*;
(
    input  logic signed [FP_W-1:0] x,
    input  logic signed [FP_W-1:0] w,
    input  logic signed [FP_W-1:0] lr,
    input  logic signed [1:0]      err,
    output logic signed [FP_W-1:0] w_new
);

    logic signed [2*FP_W-1:0] x_ext_s;
    logic signed [2*FP_W-1:0] lr_ext_s;
    logic signed [2*FP_W-1:0] prod_s;
    logic signed [FP_W-1:0]   delta_s;
    logic signed [FP_W:0]     sum_s;

    // Scaled correction and the widened weight sum.
    always_comb begin
        x_ext_s  = {{FP_W{x[FP_W-1]}}, x};
        lr_ext_s = {{FP_W{lr[FP_W-1]}}, lr};
        prod_s   = (x_ext_s * lr_ext_s) >>> FP_FRACT_W;
`ifdef PERCEPTRON_TRAINER_SATURATE_EN
        delta_s  = sat_trunc(prod_s);
`else
        delta_s  = prod_s[FP_W-1:0];
`endif
        if (err == 2'sb01) begin
            sum_s = {w[FP_W-1], w} + {delta_s[FP_W-1], delta_s};
        end else if (err == 2'sb11) begin
            sum_s = {w[FP_W-1], w} - {delta_s[FP_W-1], delta_s};
        end else begin
            sum_s = {w[FP_W-1], w};
        end
`ifdef PERCEPTRON_TRAINER_SATURATE_EN
        w_new = sat_add(sum_s);
`else
        w_new = sum_s[FP_W-1:0];
`endif
    end

endmodule

// File: rtl/perceptron_trainer.sv
// Drives a 2-input perceptron through the perceptron learning rule over a sample memory.
// Optional clamping arithmetic: PERCEPTRON_TRAINER_SATURATE_EN (see perceptron_weight_update).
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter  int N_SAMPLES  = 4,
    parameter  int MAX_EPOCHS = 16,
    localparam int ADDR_W     = $clog2(N_SAMPLES),
    localparam int EPOCH_W    = $clog2(MAX_EPOCHS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [FP_W-1:0]    lr,
    output logic               busy,
    output logic               done,
    output logic               converged,
    output logic [EPOCH_W-1:0] epochs_used,
    output logic [ADDR_W-1:0]  sample_addr,
    input  logic [FP_W-1:0]    sample_in1,
    input  logic [FP_W-1:0]    sample_in2,
    input  logic               sample_target,
    output logic [FP_W-1:0]    p_in1,
    output logic [FP_W-1:0]    p_in2,
    input  logic [FP_W-1:0]    weight1,
    input  logic [FP_W-1:0]    weight2,
    input  logic               result,
    output logic [FP_W-1:0]    w1_new,
    output logic [FP_W-1:0]    w2_new,
    output logic               w1_ld,
    output logic               w2_ld
);

    state_t               state_r, next_state_s;
    logic [ADDR_W-1:0]    idx_r;
    logic [EPOCH_W-1:0]   epoch_r;
    logic                 err_seen_r;
    logic [FP_W-1:0]      lr_r;
    logic [FP_W-1:0]      p_in1_r, p_in2_r;
    logic                 tgt_r;
    logic                 busy_r, done_r, converged_r;
    logic [EPOCH_W-1:0]   epochs_used_r;
    logic signed [1:0]    err_s;
    logic [FP_W-1:0]      w1_upd_s, w2_upd_s;
    logic                 last_idx_s, last_epoch_s;

    assign err_s        = {1'b0, tgt_r} - {1'b0, result};
    assign last_idx_s   = (idx_r == ADDR_W'(N_SAMPLES - 1));
    assign last_epoch_s = (epoch_r == EPOCH_W'(MAX_EPOCHS - 1));

    perceptron_weight_update u_upd1 (
        .x     (p_in1_r),
        .w     (weight1),
        .lr    (lr_r),
        .err   (err_s),
        .w_new (w1_upd_s)
    );

    perceptron_weight_update u_upd2 (
        .x     (p_in2_r),
        .w     (weight2),
        .lr    (lr_r),
        .err   (err_s),
        .w_new (w2_upd_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state plus the weight-load strobes, which must coincide with the valid result.
    always_comb begin
        next_state_s = state_r;
        w1_new       = {FP_W{1'b0}};
        w2_new       = {FP_W{1'b0}};
        w1_ld        = 1'b0;
        w2_ld        = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = FETCH;
                    w1_ld        = 1'b1;
                    w2_ld        = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            FETCH: next_state_s = LATCH;
            LATCH: next_state_s = CHECK;
            CHECK: begin
                next_state_s = NEXT;
                if (err_s != 2'sb00) begin
                    w1_new = w1_upd_s;
                    w2_new = w2_upd_s;
                    w1_ld  = 1'b1;
                    w2_ld  = 1'b1;
                end else begin
                    w1_ld  = 1'b0;
                    w2_ld  = 1'b0;
                end
            end
            NEXT: begin
                if (!last_idx_s) begin
                    next_state_s = FETCH;
                end else if (!err_seen_r || last_epoch_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = FETCH;
                end
            end
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Sample/epoch bookkeeping and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r         <= {ADDR_W{1'b0}};
            epoch_r       <= {EPOCH_W{1'b0}};
            err_seen_r    <= 1'b0;
            lr_r          <= {FP_W{1'b0}};
            p_in1_r       <= {FP_W{1'b0}};
            p_in2_r       <= {FP_W{1'b0}};
            tgt_r         <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            converged_r   <= 1'b0;
            epochs_used_r <= {EPOCH_W{1'b0}};
        end else begin
            busy_r <= (next_state_s == FETCH) || (next_state_s == LATCH) ||
                      (next_state_s == CHECK) || (next_state_s == NEXT);
            done_r <= (next_state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        lr_r          <= lr;
                        idx_r         <= {ADDR_W{1'b0}};
                        epoch_r       <= {EPOCH_W{1'b0}};
                        err_seen_r    <= 1'b0;
                        converged_r   <= 1'b0;
                        epochs_used_r <= {EPOCH_W{1'b0}};
                    end
                end
                LATCH: begin
                    p_in1_r <= sample_in1;
                    p_in2_r <= sample_in2;
                    tgt_r   <= sample_target;
                end
                CHECK: begin
                    if (err_s != 2'sb00) begin
                        err_seen_r <= 1'b1;
                    end
                end
                NEXT: begin
                    if (!last_idx_s) begin
                        idx_r <= idx_r + ADDR_W'(1);
                    end else begin
                        epochs_used_r <= epoch_r + EPOCH_W'(1);
                        if (!err_seen_r) begin
                            converged_r <= 1'b1;
                        end else if (!last_epoch_s) begin
                            epoch_r    <= epoch_r + EPOCH_W'(1);
                            idx_r      <= {ADDR_W{1'b0}};
                            err_seen_r <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign converged   = converged_r;
    assign epochs_used = epochs_used_r;
    assign sample_addr = idx_r;
    assign p_in1       = p_in1_r;
    assign p_in2       = p_in2_r;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Randomized bench for perceptron_trainer with a sample memory, perceptron and training reference model.
module tb_perceptron_trainer;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [15:0] lr;
    logic        busy, done, converged;
    logic [4:0]  epochs_used;
    logic [1:0]  sample_addr;
    logic [15:0] sample_in1, sample_in2;
    logic        sample_target;
    logic [15:0] p_in1, p_in2, w1_new, w2_new;
    logic        result, w1_ld, w2_ld;
    logic [15:0] pw1_r = 16'h0000;
    logic [15:0] pw2_r = 16'h0000;

    logic [15:0] mem_in1 [4];
    logic [15:0] mem_in2 [4];
    logic        mem_tgt [4];

    int checks_cnt = 0;
    int errors_cnt = 0;
    int ld1_cnt = 0, ld2_cnt = 0, done_cnt = 0;
    logic [31:0] dut_log [$];

    int ref_conv, ref_ep, ref_w1, ref_w2;
    logic [31:0] ref_log [$];

    always #5 clk = ~clk;

    perceptron_trainer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .lr(lr), .busy(busy), .done(done),
        .converged(converged), .epochs_used(epochs_used), .sample_addr(sample_addr),
        .sample_in1(sample_in1), .sample_in2(sample_in2), .sample_target(sample_target),
        .p_in1(p_in1), .p_in2(p_in2), .weight1(pw1_r), .weight2(pw2_r), .result(result),
        .w1_new(w1_new), .w2_new(w2_new), .w1_ld(w1_ld), .w2_ld(w2_ld)
    );

    function automatic int wrap16(input int v);
        logic [15:0] t;
        t = v[15:0];
        return int'($signed(t));
    endfunction

    function automatic int fit16(input int v);
`ifdef PERCEPTRON_TRAINER_SATURATE_EN
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
`else
        return wrap16(v);
`endif
    endfunction

    // Perceptron: fixed-point products and sum wrap to 16 bits; output is sum >= 0.
    function automatic logic perc(input logic [15:0] x1, x2, w1, w2);
        int a1, a2, b1, b2, s;
        a1 = int'($signed(x1)); a2 = int'($signed(x2));
        b1 = int'($signed(w1)); b2 = int'($signed(w2));
        s = wrap16(wrap16((a1 * b1) >>> 12) + wrap16((a2 * b2) >>> 12));
        return (s >= 0);
    endfunction

    assign result = perc(p_in1, p_in2, pw1_r, pw2_r);

    always @(posedge clk) begin
        if (w1_ld) pw1_r <= w1_new;
        if (w2_ld) pw2_r <= w2_new;
        sample_in1    <= mem_in1[sample_addr];
        sample_in2    <= mem_in2[sample_addr];
        sample_target <= mem_tgt[sample_addr];
    end

    always @(negedge clk) begin
        if (w1_ld) begin
            ld1_cnt++;
            dut_log.push_back({w1_new, w2_new});
        end
        if (w2_ld) ld2_cnt++;
        if (done) done_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Learning rule applied sample by sample, epoch by epoch.
    task automatic ref_train(input logic [15:0] lr_v);
        int w1, w2, err, d1, d2, x1, x2, l;
        bit errs;
        logic [15:0] tw1, tw2;
        w1 = 0; w2 = 0; l = int'($signed(lr_v));
        ref_log.delete();
        ref_conv = 0; ref_ep = 16;
        for (int e = 0; e < 16; e++) begin
            errs = 1'b0;
            for (int i = 0; i < 4; i++) begin
                tw1 = w1[15:0]; tw2 = w2[15:0];
                err = int'(mem_tgt[i]) - int'(perc(mem_in1[i], mem_in2[i], tw1, tw2));
                if (err != 0) begin
                    x1 = int'($signed(mem_in1[i])); x2 = int'($signed(mem_in2[i]));
                    d1 = fit16((x1 * l) >>> 12);
                    d2 = fit16((x2 * l) >>> 12);
                    w1 = fit16(w1 + err * d1);
                    w2 = fit16(w2 + err * d2);
                    ref_log.push_back({w1[15:0], w2[15:0]});
                    errs = 1'b1;
                end
            end
            if (!errs) begin
                ref_conv = 1; ref_ep = e + 1;
                break;
            end
        end
        ref_w1 = w1; ref_w2 = w2;
    endtask

    task automatic run_case(input string name, input logic [15:0] lr_v, input bit mid_start);
        int b_ld1, b_ld2, b_done, b_log, cyc;
        bit seen;
        logic [15:0] e1, e2;
        ref_train(lr_v);
        b_ld1 = ld1_cnt; b_ld2 = ld2_cnt; b_done = done_cnt; b_log = dut_log.size();
        @(posedge clk); #1; lr = lr_v; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; lr = 16'($urandom);
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 400) begin
            @(posedge clk); #1; cyc++;
            start = (mid_start && cyc == 5);
            if (cyc == 3) check_eq({name, "_busy"}, {31'd0, busy}, 32'd1);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check_eq({name, "_done_seen"}, {31'd0, seen}, 32'd1);
        check_eq({name, "_latency"}, cyc, ref_ep * 16);
        check_eq({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        check_eq({name, "_converged"}, {31'd0, converged}, ref_conv);
        check_eq({name, "_epochs"}, {27'd0, epochs_used}, ref_ep);
        repeat (3) @(posedge clk);
        #1;
        e1 = ref_w1[15:0]; e2 = ref_w2[15:0];
        check_eq({name, "_done_pulses"}, done_cnt - b_done, 32'd1);
        check_eq({name, "_weight1"}, {16'd0, pw1_r}, {16'd0, e1});
        check_eq({name, "_weight2"}, {16'd0, pw2_r}, {16'd0, e2});
        check_eq({name, "_ld1_count"}, ld1_cnt - b_ld1, ref_log.size() + 1);
        check_eq({name, "_ld2_count"}, ld2_cnt - b_ld2, ref_log.size() + 1);
        if (dut_log.size() > b_log) check_eq({name, "_clear"}, dut_log[b_log], 32'd0);
        for (int k = 0; k < ref_log.size(); k++) begin
            if (b_log + 1 + k < dut_log.size())
                check_eq({name, "_upd"}, dut_log[b_log + 1 + k], ref_log[k]);
        end
    endtask

    task automatic load_t1();
        mem_in1[0] = 16'h1000; mem_in2[0] = 16'h0800; mem_tgt[0] = 1'b1;
        mem_in1[1] = 16'hF000; mem_in2[1] = 16'h0800; mem_tgt[1] = 1'b0;
        mem_in1[2] = 16'h0800; mem_in2[2] = 16'hF000; mem_tgt[2] = 1'b1;
        mem_in1[3] = 16'hF800; mem_in2[3] = 16'hF000; mem_tgt[3] = 1'b0;
    endtask

    task automatic check_t1(input string name);
        check_eq({name, "_conv_const"}, {31'd0, converged}, 32'd1);
        check_eq({name, "_ep_const"}, {27'd0, epochs_used}, 32'd2);
        check_eq({name, "_w1_const"}, {16'd0, pw1_r}, 32'h0C00);
        check_eq({name, "_w2_const"}, {16'd0, pw2_r}, 32'h0400);
    endtask

    initial begin
        int b_log, b_done;
        logic [31:0] tmp;
        rst_n = 1'b0; start = 1'b0; lr = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            mem_in1[i] = 16'h0000; mem_in2[i] = 16'h0000; mem_tgt[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_status", {26'd0, converged, epochs_used}, 32'd0);
        check_eq("rst_pin", {p_in1, p_in2}, 32'd0);
        check_eq("rst_addr_ld", {29'd0, sample_addr, w1_ld | w2_ld}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        load_t1();
        run_case("t1", 16'h0800, 1'b0);
        check_t1("t1");

        for (int i = 0; i < 4; i++) begin
            mem_in1[i] = 16'($urandom); mem_in2[i] = 16'($urandom); mem_tgt[i] = 1'b1;
        end
        run_case("t2", 16'($urandom_range(1, 16'h2000)), 1'b0);

        for (int i = 0; i < 4; i++) begin
            mem_in1[i] = 16'h1000; mem_in2[i] = 16'h0800; mem_tgt[i] = (i % 2 == 0);
        end
        run_case("t3", 16'h0800, 1'b0);
        check_eq("t3_ep_const", {27'd0, epochs_used}, 32'd16);

        mem_in1[0] = 16'h1C00; mem_in2[0] = 16'h0000; mem_tgt[0] = 1'b0;
        mem_in1[1] = 16'hE400; mem_in2[1] = 16'h0000; mem_tgt[1] = 1'b1;
        mem_in1[2] = 16'h0000; mem_in2[2] = 16'h0000; mem_tgt[2] = 1'b1;
        mem_in1[3] = 16'h0000; mem_in2[3] = 16'h0000; mem_tgt[3] = 1'b1;
        b_log = dut_log.size();
        run_case("t4", 16'h4000, 1'b0);
        tmp = (dut_log.size() > b_log + 1) ? dut_log[b_log + 1] : 32'hDEAD_BEEF;
        check_eq("t4_s0_w1", {16'd0, tmp[31:16]}, 32'h9000);
        tmp = (dut_log.size() > b_log + 2) ? dut_log[b_log + 2] : 32'hDEAD_BEEF;
`ifdef PERCEPTRON_TRAINER_SATURATE_EN
        check_eq("t4_s1_w1", {16'd0, tmp[31:16]}, 32'h8000);
`else
        check_eq("t4_s1_w1", {16'd0, tmp[31:16]}, 32'h2000);
`endif

        load_t1();
        run_case("t5_midstart", 16'h0800, 1'b1);
        check_t1("t5_midstart");

        b_done = done_cnt;
        @(posedge clk); #1; lr = 16'h0800; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2; rst_n = 1'b0;
        #1;
        check_eq("t5_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("t5_rst_pin", {p_in1, p_in2}, 32'd0);
        check_eq("t5_rst_ld", {30'd0, w1_ld, w2_ld}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("t5_rst_no_done", done_cnt - b_done, 32'd0);
        run_case("t5_after_rst", 16'h0800, 1'b0);
        check_t1("t5_after_rst");

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) begin
                mem_in1[i] = 16'(int'($urandom_range(0, 16383)) - 8192);
                mem_in2[i] = 16'(int'($urandom_range(0, 16383)) - 8192);
                mem_tgt[i] = 1'($urandom_range(0, 1));
            end
            run_case($sformatf("rnd%0d", r), 16'($urandom_range(0, 16'h3000)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
